// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Purpose  : Shared constants for the 5-digit multiplexed 7-segment driver:
//             digit geometry, active-low segment codes, idle select/LED words.
//  Revision : 1.0  initial release
// ============================================================================
package seg_pkg;

    // Display geometry
    localparam int NUM_DIG = 5;
    localparam int DIG_W   = 4;
    localparam int IDX_W   = 3;

    // Active-low segment patterns, bit order g f e d c b a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Idle output words: no digit enabled, every segment (and dp) dark
    localparam logic [NUM_DIG-1:0] SEL_NONE = 5'b11111;
    localparam logic [7:0]         LED_OFF  = 8'hFF;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_seg7
//  Purpose  : Combinational BCD nibble to active-low gfedcba pattern.
//             Non-decimal nibbles (10..15) render as a dark digit.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_to_seg7
    import seg_pkg::*;
(
    input  logic [DIG_W-1:0] nibble,
    output logic [6:0]       seg
);

    // Nibble lookup; anything outside 0..9 is blanked
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/seg_scan_drv.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_drv
//  Purpose  : Time-multiplexes a 20-bit BCD word onto a common-anode 5-digit
//             7-segment display. Inputs are snapshotted once per frame so a
//             frame never mixes old and new data; each digit slot starts with
//             a dark interval to suppress ghosting; digits can blink and carry
//             individual decimal points. All outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_drv
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int BLINK_DIV = 25000000
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_DIG*DIG_W-1:0] seg_data,
    input  logic [NUM_DIG-1:0]       blink_mask,
    input  logic [NUM_DIG-1:0]       dp_mask,
    output logic [NUM_DIG-1:0]       seg_sel,
    output logic [7:0]               seg_led
);

    // Counter widths sized from the division ratios
    localparam int PRE_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRE_W-1:0] c_pre_last  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] c_blank_end = PRE_W'(BLANK_CYC);
    localparam logic [BLK_W-1:0] c_blk_last  = BLK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(NUM_DIG - 1);

    // Scan timing state
    logic [PRE_W-1:0]         r_pre;
    logic [IDX_W-1:0]         r_idx;

    // Blink timing state
    logic [BLK_W-1:0]         r_blk_cnt;
    logic                     r_blk_phase;

    // Per-frame snapshot of the inputs
    logic [NUM_DIG*DIG_W-1:0] r_data;
    logic [NUM_DIG-1:0]       r_blink;
    logic [NUM_DIG-1:0]       r_dp;

    // Registered pin drivers
    logic [NUM_DIG-1:0]       r_sel;
    logic [7:0]               r_led;

    // Current-digit view of the snapshot
    logic                     w_frame_start;
    logic                     w_pre_wrap;
    logic                     w_in_blank;
    logic [DIG_W-1:0]         w_nibble;
    logic                     w_dp_on;
    logic                     w_blink_on;
    logic [NUM_DIG-1:0]       w_sel;
    logic [6:0]               w_seg;

    assign w_frame_start = (r_pre == '0) && (r_idx == '0);
    assign w_pre_wrap    = (r_pre == c_pre_last);
    assign w_in_blank    = (r_pre < c_blank_end);

    // Exactly one enable low for a valid index; out-of-range index stays dark
    assign w_sel = ~(NUM_DIG'(1) << r_idx);

    // Select the nibble, dp and blink flag belonging to the digit being scanned
    always_comb begin
        w_nibble   = r_data[DIG_W-1:0];
        w_dp_on    = r_dp[0];
        w_blink_on = r_blink[0];
        case (r_idx)
            3'd0: begin
                w_nibble   = r_data[3:0];
                w_dp_on    = r_dp[0];
                w_blink_on = r_blink[0];
            end
            3'd1: begin
                w_nibble   = r_data[7:4];
                w_dp_on    = r_dp[1];
                w_blink_on = r_blink[1];
            end
            3'd2: begin
                w_nibble   = r_data[11:8];
                w_dp_on    = r_dp[2];
                w_blink_on = r_blink[2];
            end
            3'd3: begin
                w_nibble   = r_data[15:12];
                w_dp_on    = r_dp[3];
                w_blink_on = r_blink[3];
            end
            3'd4: begin
                w_nibble   = r_data[19:16];
                w_dp_on    = r_dp[4];
                w_blink_on = r_blink[4];
            end
            default: begin
                w_nibble   = r_data[3:0];
                w_dp_on    = 1'b0;
                w_blink_on = 1'b0;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .nibble (w_nibble),
        .seg    (w_seg)
    );

    // Slot prescaler and digit index: index advances each time the slot ends
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_pre_wrap) begin
            r_pre <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Free-running blink timebase; phase 1 means blinking digits are dark
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_cnt   <= '0;
            r_blk_phase <= 1'b0;
        end else if (r_blk_cnt == c_blk_last) begin
            r_blk_cnt   <= '0;
            r_blk_phase <= ~r_blk_phase;
        end else begin
            r_blk_cnt   <= r_blk_cnt + BLK_W'(1);
        end
    end

    // Snapshot data and masks at the start of each frame only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_blink <= '0;
            r_dp    <= '0;
        end else if (w_frame_start) begin
            r_data  <= seg_data;
            r_blink <= blink_mask;
            r_dp    <= dp_mask;
        end
    end

    // Pin drivers: dark during the slot lead-in, otherwise the current digit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= SEL_NONE;
            r_led <= LED_OFF;
        end else if (w_in_blank) begin
            r_sel <= SEL_NONE;
            r_led <= LED_OFF;
        end else begin
            r_sel <= w_sel;
            if (w_blink_on && r_blk_phase) begin
                r_led <= LED_OFF;
            end else begin
                r_led <= {~w_dp_on, w_seg};
            end
        end
    end

    assign seg_sel = r_sel;
    assign seg_led = r_led;

endmodule : seg_scan_drv
`default_nettype wire

// File: tb/tb_seg_scan_drv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_drv
//  Purpose  : Scoreboard bench for seg_scan_drv with SCAN_DIV=4, BLANK_CYC=1,
//             BLINK_DIV=64. Stimulus queues the hand-derived {sel,led} of
//             every digit slot it expects; a monitor pops one entry at the
//             first lit cycle of each slot and checks slot shape and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_drv;

    logic        clk;
    logic        rst;
    logic [19:0] seg_data;
    logic [4:0]  blink_mask;
    logic [4:0]  dp_mask;
    logic [4:0]  seg_sel;
    logic [7:0]  seg_led;

    logic        rst_q;
    logic [12:0] exp_q[$];

    int passed;
    int total;
    int onehot_err;

    seg_scan_drv #(
        .SCAN_DIV  (4),
        .BLANK_CYC (1),
        .BLINK_DIV (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_data   (seg_data),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .seg_sel    (seg_sel),
        .seg_led    (seg_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the first n slots of a frame (digit 0 first) with given LED bytes
    task automatic push_frame(input int n, input logic [7:0] l0, input logic [7:0] l1,
                              input logic [7:0] l2, input logic [7:0] l3, input logic [7:0] l4);
        logic [7:0] leds [5];
        logic [4:0] sels [5];
        leds = '{l0, l1, l2, l3, l4};
        sels = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h0F};
        for (int i = 0; i < n; i++) exp_q.push_back({sels[i], leds[i]});
    endtask

    // Monitor: reset outputs, one-hot-low enables, slot shape, slot contents
    initial begin : monitor
        int          lit_run;
        int          blank_run;
        bit          tainted;
        logic [12:0] slot_val;
        logic [12:0] exp_val;
        lit_run   = 0;
        blank_run = 0;
        tainted   = 1'b1;
        slot_val  = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst_q) begin
                check("reset_out", {19'd0, seg_sel, seg_led}, {19'd0, 5'h1F, 8'hFF});
                tainted   = 1'b1;
                lit_run   = 0;
                blank_run = 0;
            end else begin
                if (!(seg_sel == 5'h1F || $countones(~seg_sel) == 1)) onehot_err++;
                if (seg_sel == 5'h1F) begin
                    check("blank_led", {24'd0, seg_led}, 32'hFF);
                    if (lit_run != 0) begin
                        if (!tainted) check("lit_run_len", lit_run, 3);
                        lit_run = 0;
                    end
                    blank_run++;
                end else begin
                    if (lit_run == 0) begin
                        if (!tainted) check("blank_run_len", blank_run, 1);
                        tainted   = 1'b0;
                        blank_run = 0;
                        slot_val  = {seg_sel, seg_led};
                        if (exp_q.size() == 0) begin
                            total++;
                            $display("FAIL unexpected_slot: got sel=%h led=%h, expected no slot (t=%0t)",
                                     seg_sel, seg_led, $time);
                        end else begin
                            exp_val = exp_q.pop_front();
                            check("slot", {19'd0, seg_sel, seg_led}, {19'd0, exp_val});
                        end
                    end else begin
                        check("slot_hold", {19'd0, seg_sel, seg_led}, {19'd0, slot_val});
                    end
                    lit_run++;
                end
            end
        end
    end

    // Stimulus: edge count after reset release is tracked in comments as pos
    initial begin : stimulus
        passed     = 0;
        total      = 0;
        onehot_err = 0;
        rst        = 1'b1;
        seg_data   = 20'h12345;
        blink_mask = 5'b00000;
        dp_mask    = 5'b00000;

        // Reset held for three edges; frame 0 latches 12345 on release
        push_frame(5, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        wait_edges(3);
        rst = 1'b0;
        wait_edges(1);                                        // pos 1

        // Frame 1: 98760, change made mid frame 0 must not leak into it
        seg_data = 20'h98760;
        push_frame(5, 8'hC0, 8'h82, 8'hF8, 8'h80, 8'h90);
        wait_edges(20);                                       // pos 21

        // Frame 2: non-decimal digits blank, dp on digit 1
        seg_data = 20'hFA000;
        dp_mask  = 5'b00010;
        push_frame(5, 8'hC0, 8'h40, 8'hC0, 8'hFF, 8'hFF);
        wait_edges(20);                                       // pos 41

        // Frame 3: all ones, then switch to twos while digit 2 is lit
        seg_data = 20'h11111;
        dp_mask  = 5'b00000;
        push_frame(5, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9);
        wait_edges(29);                                       // pos 70
        seg_data = 20'h22222;
        push_frame(5, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hA4);     // frame 4
        wait_edges(11);                                       // pos 81

        // Frames 5..10: digit 0 blinks; phase 1 over cycles 64-127 and 192-255
        seg_data   = 20'h54321;
        blink_mask = 5'b00001;
        push_frame(5, 8'hFF, 8'hA4, 8'hB0, 8'h99, 8'h92);     // frame 5
        push_frame(5, 8'hFF, 8'hA4, 8'hB0, 8'h99, 8'h92);     // frame 6
        push_frame(5, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92);     // frame 7
        push_frame(5, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92);     // frame 8
        push_frame(5, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92);     // frame 9
        push_frame(5, 8'hFF, 8'hA4, 8'hB0, 8'h99, 8'h92);     // frame 10
        wait_edges(120);                                      // pos 201

        // Frame 11: reset lands during digit 3, digit 4 never appears
        seg_data   = 20'h13579;
        blink_mask = 5'b00000;
        push_frame(4, 8'h90, 8'hF8, 8'h92, 8'hB0, 8'hFF);
        wait_edges(33);                                       // pos 234
        rst = 1'b1;
        wait_edges(1);
        rst      = 1'b0;
        seg_data = 20'h24680;
        push_frame(5, 8'hC0, 8'h80, 8'h82, 8'h99, 8'hA4);
        wait_edges(20);

        check("queue_drained", exp_q.size(), 0);
        check("onehot_low_sel", onehot_err, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_seg_scan_drv
`default_nettype wire
